// File: rtl/fifo_dedup_writer.sv
// ---------------------------------------------------------------------------
// fifo_dedup_writer
//   Front end for the checking FIFO. Each upstream word is latched, the FIFO
//   is asked whether the word is already queued, and the word is written only
//   if it is absent. Duplicates are dropped and counted. A check that never
//   completes is abandoned after TIMEOUT cycles. In that case the word is
//   written anyway and timeout_err pulses.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   in_vld/in_rdy/in_dat     upstream valid/ready stream
//   wren/wdat                FIFO write strobe and data
//   full/empty               FIFO status
//   check_req/check_dat      one-cycle search request and the value to search
//   check_res/check_vld      search result, qualified by check_vld
//   busy                     a word is in flight (state != IDLE)
//   dup_drop/timeout_err     one-cycle event pulses
//   wr_cnt/drop_cnt          saturating statistics counters
// ---------------------------------------------------------------------------
module fifo_dedup_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int TO_WIDTH   = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  wren,
  output logic [DATA_WIDTH-1:0] wdat,
  input  logic                  full,
  input  logic                  empty,
  output logic                  check_req,
  output logic [DATA_WIDTH-1:0] check_dat,
  input  logic                  check_res,
  input  logic                  check_vld,
  output logic                  busy,
  output logic                  dup_drop,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BLANK = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [TO_WIDTH-1:0]  TIMER_LAST = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0]  TIMER_ONE  = TO_WIDTH'(1);

  state_t                  state_r;
  state_t                  next_state_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [TO_WIDTH-1:0]     timer_r;
  logic [CNT_WIDTH-1:0]    wr_cnt_r;
  logic [CNT_WIDTH-1:0]    drop_cnt_r;

  logic                    load_s;
  logic                    timer_clr_s;
  logic                    timer_inc_s;
  logic                    wren_s;
  logic                    check_req_s;
  logic                    dup_drop_s;
  logic                    timeout_err_s;

  // Next-state and per-state strobes.
  always_comb begin
    next_state_s  = state_r;
    load_s        = 1'b0;
    timer_clr_s   = 1'b0;
    timer_inc_s   = 1'b0;
    wren_s        = 1'b0;
    check_req_s   = 1'b0;
    dup_drop_s    = 1'b0;
    timeout_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_vld) begin
          load_s = 1'b1;
          // An empty FIFO never terminates a search, so skip the check.
          if (empty) begin
            next_state_s = ST_WRITE;
          end else begin
            next_state_s = ST_REQ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        check_req_s  = 1'b1;
        next_state_s = ST_BLANK;
      end
      ST_BLANK: begin
        // The FIFO compare register is still stale here; its result is ignored.
        timer_clr_s  = 1'b1;
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (check_vld) begin
          if (check_res) begin
            dup_drop_s   = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_WRITE;
          end
        end else if (timer_r == TIMER_LAST) begin
          timeout_err_s = 1'b1;
          next_state_s  = ST_WRITE;
        end else begin
          timer_inc_s  = 1'b1;
          next_state_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (!full) begin
          wren_s       = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Held word: captured on acceptance, kept until written or dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (load_s) begin
      data_r <= in_dat;
    end
  end

  // Check timeout timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r <= {TO_WIDTH{1'b0}};
    end else if (timer_clr_s) begin
      timer_r <= {TO_WIDTH{1'b0}};
    end else if (timer_inc_s) begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_r   <= {CNT_WIDTH{1'b0}};
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (wren_s && (wr_cnt_r != CNT_MAX)) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end
      if (dup_drop_s && (drop_cnt_r != CNT_MAX)) begin
        drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
    end
  end

  assign in_rdy      = (state_r == ST_IDLE);
  assign busy        = (state_r != ST_IDLE);
  assign wren        = wren_s;
  assign wdat        = data_r;
  assign check_req   = check_req_s;
  assign check_dat   = data_r;
  assign dup_drop    = dup_drop_s;
  assign timeout_err = timeout_err_s;
  assign wr_cnt      = wr_cnt_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_fifo_dedup_writer.sv
// ---------------------------------------------------------------------------
// tb_fifo_dedup_writer
//   Bench for fifo_dedup_writer. The bench plays the FIFO: it keeps the queued
//   words in a queue, derives empty from it, and answers searches by looking
//   the word up in that queue. Expected counters come from event counting with
//   saturation. The counters are narrowed to 4 bits so that saturation is
//   reachable.
// ---------------------------------------------------------------------------
module tb_fifo_dedup_writer;

  localparam int DW   = 32;
  localparam int TO   = 64;
  localparam int CW   = 4;
  localparam logic [CW-1:0] CMAX = 4'hF;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_dat;
  logic          wren;
  logic [DW-1:0] wdat;
  logic          full;
  logic          empty;
  logic          check_req;
  logic [DW-1:0] check_dat;
  logic          check_res;
  logic          check_vld;
  logic          busy;
  logic          dup_drop;
  logic          timeout_err;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] drop_cnt;

  int            errors;
  int            checks;
  logic [DW-1:0] fq[$];
  logic [CW-1:0] exp_wr;
  logic [CW-1:0] exp_drop;

  fifo_dedup_writer #(
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO),
    .TO_WIDTH  (7),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_dat     (in_dat),
    .wren       (wren),
    .wdat       (wdat),
    .full       (full),
    .empty      (empty),
    .check_req  (check_req),
    .check_dat  (check_dat),
    .check_res  (check_res),
    .check_vld  (check_vld),
    .busy       (busy),
    .dup_drop   (dup_drop),
    .timeout_err(timeout_err),
    .wr_cnt     (wr_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit fq_has(input logic [DW-1:0] v);
    foreach (fq[i]) begin
      if (fq[i] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One upstream word from acceptance to the following idle cycle. Inputs
  // change on the falling edge; outputs are observed 1 time unit later.
  task automatic run_word(input logic [DW-1:0] d, input int full_cycles,
                          input int resp_delay, input bit blank_vld,
                          input bit force_to);
    bit dup;
    bit do_write;
    int n_idle;
    dup = 1'b0;
    @(negedge clk);
    in_vld = 1'b1; in_dat = d; empty = (fq.size() == 0);
    full = 1'b0; check_vld = 1'b0; check_res = 1'b0;
    #1;
    checks++;
    if ({in_rdy, busy} !== 2'b10)
      begin errors++; $display("FAIL accept: in_rdy,busy=%b required 10", {in_rdy, busy}); end
    if (fq.size() == 0) begin
      do_write = 1'b1;
    end else begin
      @(negedge clk);
      in_vld = 1'b0; in_dat = $urandom;
      #1;
      checks++;
      if ({check_req, busy, in_rdy, wren} !== 4'b1100 || check_dat !== d)
        begin errors++; $display("FAIL req: req,busy,rdy,wren=%b dat=%h required 1100 %h", {check_req, busy, in_rdy, wren}, check_dat, d); end
      @(negedge clk);
      check_vld = blank_vld; check_res = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({check_req, wren, dup_drop, timeout_err, in_rdy} !== 5'b00000)
        begin errors++; $display("FAIL blank: req,wren,dup,to,rdy=%b required 00000", {check_req, wren, dup_drop, timeout_err, in_rdy}); end
      dup    = fq_has(d) && !force_to;
      n_idle = force_to ? TO - 1 : resp_delay;
      for (int i = 0; i < n_idle; i++) begin
        @(negedge clk);
        check_vld = 1'b0; check_res = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({wren, dup_drop, timeout_err, in_rdy, busy} !== 5'b00001)
          begin errors++; $display("FAIL wait%0d: wren,dup,to,rdy,busy=%b required 00001", i, {wren, dup_drop, timeout_err, in_rdy, busy}); end
      end
      @(negedge clk);
      check_vld = !force_to; check_res = fq_has(d);
      #1;
      checks++;
      if ({wren, dup_drop, timeout_err} !== {1'b0, dup, force_to})
        begin errors++; $display("FAIL result: wren,dup,to=%b required %b", {wren, dup_drop, timeout_err}, {1'b0, dup, force_to}); end
      do_write = !dup;
      if (dup && exp_drop != CMAX) exp_drop++;
    end
    if (do_write) begin
      for (int i = 0; i < full_cycles; i++) begin
        @(negedge clk);
        in_vld = 1'b0; check_vld = 1'b0; full = 1'b1;
        #1;
        checks++;
        if ({wren, in_rdy, busy} !== 3'b001 || wdat !== d)
          begin errors++; $display("FAIL stall%0d: wren,rdy,busy=%b wdat=%h required 001 %h", i, {wren, in_rdy, busy}, wdat, d); end
      end
      @(negedge clk);
      in_vld = 1'b0; check_vld = 1'b0; full = 1'b0;
      #1;
      checks++;
      if ({wren, check_req, busy} !== 3'b101 || wdat !== d)
        begin errors++; $display("FAIL write: wren,req,busy=%b wdat=%h required 101 %h", {wren, check_req, busy}, wdat, d); end
      if (exp_wr != CMAX) exp_wr++;
      fq.push_back(d);
    end
    @(negedge clk);
    in_vld = 1'b0; check_vld = 1'b0; full = 1'b0;
    #1;
    checks++;
    if ({in_rdy, busy, wren, dup_drop} !== 4'b1000 || wr_cnt !== exp_wr || drop_cnt !== exp_drop)
      begin errors++; $display("FAIL idle: rdy,busy,wren,dup=%b wr=%0d drop=%0d required 1000 %0d %0d", {in_rdy, busy, wren, dup_drop}, wr_cnt, drop_cnt, exp_wr, exp_drop); end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_vld = 1'b0; in_dat = '0; full = 1'b0; empty = 1'b1;
    check_vld = 1'b0; check_res = 1'b0;
    exp_wr = '0; exp_drop = '0;
    #3;
    checks++;
    if ({in_rdy, busy, wren, check_req, dup_drop, timeout_err} !== 6'b100000 ||
        wdat !== '0 || check_dat !== '0 || wr_cnt !== '0 || drop_cnt !== '0)
      begin errors++; $display("FAIL reset: flags=%b wdat=%h cdat=%h wr=%0d drop=%0d required 100000 0 0 0 0", {in_rdy, busy, wren, check_req, dup_drop, timeout_err}, wdat, check_dat, wr_cnt, drop_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_empty_path();
    fq.delete();
    run_word(32'hA5, 0, 0, 1'b0, 1'b0);
    checks++;
    if (wr_cnt !== 4'd1)
      begin errors++; $display("FAIL empty_cnt: wr_cnt=%0d required 1", wr_cnt); end
  endtask

  task automatic test_duplicate();
    fq.delete(); fq.push_back(32'h11); fq.push_back(32'h22);
    run_word(32'h22, 0, 1, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 4'd1)
      begin errors++; $display("FAIL dup_cnt: drop_cnt=%0d required 1", drop_cnt); end
  endtask

  task automatic test_unique();
    fq.delete(); fq.push_back(32'h11);
    run_word(32'h33, 0, 0, 1'b0, 1'b0);
    checks++;
    if (wr_cnt !== 4'd2)
      begin errors++; $display("FAIL unique_cnt: wr_cnt=%0d required 2", wr_cnt); end
  endtask

  task automatic test_full_stall();
    fq.delete();
    run_word(32'hC0DE, 5, 0, 1'b0, 1'b0);
    fq.delete(); fq.push_back(32'h1);
    run_word(32'h2, 5, 2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    fq.delete(); fq.push_back(32'h44);
    run_word(32'h44, 1, 0, 1'b0, 1'b1);
    // A done indication during BLANK must not end the check early.
    fq.delete(); fq.push_back(32'h55);
    run_word(32'h55, 0, 3, 1'b1, 1'b0);
    fq.delete(); fq.push_back(32'h56);
    run_word(32'h57, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    fq.delete(); fq.push_back(32'h77);
    @(negedge clk);
    in_vld = 1'b1; in_dat = 32'h77; empty = 1'b0;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({busy, in_rdy} !== 2'b10)
      begin errors++; $display("FAIL pre_rst: busy,rdy=%b required 10", {busy, in_rdy}); end
    rst = 1'b0;
    #1;
    checks++;
    if ({in_rdy, busy, wren, check_req, dup_drop, timeout_err} !== 6'b100000 ||
        wdat !== '0 || check_dat !== '0 || wr_cnt !== '0 || drop_cnt !== '0)
      begin errors++; $display("FAIL async_rst: flags=%b wdat=%h cdat=%h wr=%0d drop=%0d required 100000 0 0 0 0", {in_rdy, busy, wren, check_req, dup_drop, timeout_err}, wdat, check_dat, wr_cnt, drop_cnt); end
    exp_wr = '0; exp_drop = '0;
    @(negedge clk);
    rst = 1'b1;
    run_word(32'h78, 0, 1, 1'b0, 1'b0);
    run_word(32'h77, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    fq.delete();
    for (int n = 0; n < 60; n++) begin
      d = DW'($urandom_range(0, 5));
      if (fq.size() > 4 || $urandom_range(0, 9) == 0) void'(fq.pop_front());
      run_word(d, $urandom_range(0, 2), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 18; n++) begin
      fq.delete();
      run_word($urandom, 0, 0, 1'b0, 1'b0);
    end
    for (int n = 0; n < 18; n++) begin
      fq.delete(); fq.push_back(32'h5);
      run_word(32'h5, 0, $urandom_range(0, 2), 1'b0, 1'b0);
    end
    checks++;
    if (wr_cnt !== CMAX || drop_cnt !== CMAX)
      begin errors++; $display("FAIL saturate: wr=%0d drop=%0d required 15 15", wr_cnt, drop_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_empty_path();
    test_duplicate();
    test_unique();
    test_full_stall();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
